// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch-PC sequencer and its return-address stack.
package pc_pkg;

    localparam logic ILEN_2B = 1'b0;
    localparam logic ILEN_4B = 1'b1;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_RAS,
        NPC_REDIR,
        NPC_TRAP,
        NPC_HOLD
    } npc_sel_e;

    // Byte step to the next sequential instruction; 4-byte-only cores always step by 4.
    function automatic logic [2:0] seq_step(input logic compressed, input logic inst_len);
        return (!compressed || inst_len == ILEN_4B) ? 3'd4 : 3'd2;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push onto a full stack overwrites the oldest entry.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] top_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_m1;
    logic [PTR_W-1:0] wr_idx;
    logic             wr_en;

    // ptr_q is the next free slot; the top entry sits just below it.
    assign ptr_m1  = ptr_q - PTR_W'(1);
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign top_o   = empty_o ? '0 : mem_q[ptr_m1];

    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        if (flush_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i && pop_i && !empty_o) begin
            // Call and return together: replace the top entry in place.
            wr_en  = 1'b1;
            wr_idx = ptr_m1;
        end else if (push_i) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_W'(1);
            if (!full_o) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_m1;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset: reads are masked while the stack is empty.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_idx] <= din_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-PC generator: picks next PC from trap, redirect, stall, return prediction or sequential step.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned         REG_BITS   = 32,
    parameter logic [REG_BITS-1:0] RESET_VEC  = '0,
    parameter logic [REG_BITS-1:0] TRAP_VEC   = REG_BITS'(32'h100),
    parameter int unsigned         RAS_DEPTH  = 4,
    parameter int unsigned         COMPRESSED = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                stall_i,
    input  logic                inst_len_i,
    input  logic                call_i,
    input  logic                ret_i,
    input  logic                redirect_valid_i,
    input  logic [REG_BITS-1:0] redirect_pc_i,
    input  logic                trap_i,
    output logic [REG_BITS-1:0] pc_o,
    output logic [REG_BITS-1:0] pc_next_seq_o,
    output logic [REG_BITS-1:0] ras_top_o,
    output logic                ras_empty_o,
    output logic                ras_full_o,
    output logic                misaligned_o
);

    localparam logic [REG_BITS-1:0] ILLEGAL_MASK =
        (COMPRESSED != 0) ? REG_BITS'(1) : REG_BITS'(3);

    npc_sel_e            npc_sel;
    logic [REG_BITS-1:0] pc_q, pc_d;
    logic                mis_q, mis_d;
    logic [REG_BITS-1:0] redir_aligned;
    logic                ras_push;
    logic                ras_pop;
    logic                ras_flush;

    assign pc_next_seq_o = pc_q + REG_BITS'(seq_step(COMPRESSED != 0, inst_len_i));
    assign redir_aligned = redirect_pc_i & ~ILLEGAL_MASK;

    // Priority encoder: trap > redirect > stall > return prediction > sequential.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (trap_i) begin
            npc_sel = NPC_TRAP;
        end else if (redirect_valid_i) begin
            npc_sel = NPC_REDIR;
        end else if (stall_i) begin
            npc_sel = NPC_HOLD;
        end else if (ret_i && !ras_empty_o) begin
            npc_sel = NPC_RAS;
        end
    end

    always_comb begin
        pc_d  = pc_next_seq_o;
        mis_d = 1'b0;
        case (npc_sel)
            NPC_TRAP:  pc_d = TRAP_VEC;
            NPC_REDIR: begin
                pc_d  = redir_aligned;
                mis_d = |(redirect_pc_i & ILLEGAL_MASK);
            end
            NPC_HOLD:  pc_d = pc_q;
            NPC_RAS:   pc_d = ras_top_o;
            default:   pc_d = pc_next_seq_o;
        endcase
    end

    // Calls only take effect on the sequential and return-prediction paths.
    assign ras_push  = call_i && (npc_sel == NPC_SEQ || npc_sel == NPC_RAS);
    assign ras_pop   = (npc_sel == NPC_RAS);
    assign ras_flush = (npc_sel == NPC_TRAP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q  <= RESET_VEC;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
        end
    end

    assign pc_o         = pc_q;
    assign misaligned_o = mis_q;

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (REG_BITS)
    ) u_ras (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .flush_i (ras_flush),
        .din_i   (pc_next_seq_o),
        .top_o   (ras_top_o),
        .empty_o (ras_empty_o),
        .full_o  (ras_full_o)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one compressed-capable and one 4-byte-only instance on shared inputs.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        inst_len;
    logic        call;
    logic        ret;
    logic        redir_v;
    logic [31:0] redir_pc;
    logic        trap;

    logic [31:0] pc_a, nseq_a, top_a;
    logic        empty_a, full_a, mis_a;
    logic [31:0] pc_b, nseq_b, top_b;
    logic        empty_b, full_b, mis_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.COMPRESSED(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .inst_len_i(inst_len),
        .call_i(call), .ret_i(ret), .redirect_valid_i(redir_v),
        .redirect_pc_i(redir_pc), .trap_i(trap),
        .pc_o(pc_a), .pc_next_seq_o(nseq_a), .ras_top_o(top_a),
        .ras_empty_o(empty_a), .ras_full_o(full_a), .misaligned_o(mis_a)
    );

    pc_sequencer #(.COMPRESSED(0)) u_dut_c0 (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .inst_len_i(inst_len),
        .call_i(call), .ret_i(ret), .redirect_valid_i(redir_v),
        .redirect_pc_i(redir_pc), .trap_i(trap),
        .pc_o(pc_b), .pc_next_seq_o(nseq_b), .ras_top_o(top_b),
        .ras_empty_o(empty_b), .ras_full_o(full_b), .misaligned_o(mis_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; call = 0; ret = 0; redir_v = 0; trap = 0;
    endtask

    initial begin
        rst = 1; inst_len = 1; redir_pc = '0;
        idle();
        step(); step();
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_empty", 32'(empty_a), 32'd1);
        chk("rst_full", 32'(full_a), 32'd0);
        chk("rst_top", top_a, 32'h0);
        chk("rst_mis", 32'(mis_a), 32'd0);

        // Sequential from reset, then asynchronous reset mid-run with RAS occupied
        rst = 0;
        chk("seq0", pc_a, 32'h0);
        step(); chk("seq4", pc_a, 32'h4);
        step(); chk("seq8", pc_a, 32'h8);
        call = 1; step(); call = 0;
        chk("call_pc", pc_a, 32'hC);
        chk("call_top", top_a, 32'hC);
        #2 rst = 1; #1;
        chk("async_pc", pc_a, 32'h0);
        chk("async_empty", 32'(empty_a), 32'd1);
        chk("async_top", top_a, 32'h0);
        step(); rst = 0;
        step(); chk("post_rst", pc_a, 32'h4);

        // Mixed instruction lengths on both instances
        redir_v = 1; redir_pc = 32'h10; step(); redir_v = 0;
        chk("mix_a0", pc_a, 32'h10);
        chk("mix_b0", pc_b, 32'h10);
        inst_len = 0; step();
        chk("mix_a1", pc_a, 32'h12);
        chk("mix_b1", pc_b, 32'h14);
        inst_len = 1; step();
        chk("mix_a2", pc_a, 32'h16);
        chk("mix_b2", pc_b, 32'h18);
        inst_len = 0; step();
        chk("mix_a3", pc_a, 32'h18);
        chk("mix_b3", pc_b, 32'h1C);
        chk("nseq_a", nseq_a, 32'h1A);
        chk("nseq_b", nseq_b, 32'h20);
        inst_len = 1;

        // Call at 0x20, jump to 0x80, return from 0x84
        redir_v = 1; redir_pc = 32'h20; step(); redir_v = 0;
        call = 1; step(); call = 0;
        chk("cr_pc", pc_a, 32'h24);
        chk("cr_top", top_a, 32'h24);
        redir_v = 1; redir_pc = 32'h80; step(); redir_v = 0;
        chk("cr_jump", pc_a, 32'h80);
        chk("cr_keep", top_a, 32'h24);
        step(); chk("cr_84", pc_a, 32'h84);
        ret = 1; step(); ret = 0;
        chk("cr_ret", pc_a, 32'h24);
        chk("cr_empty", 32'(empty_a), 32'd1);

        // Stall blocks a call; trap overrides redirect and stall and flushes RAS
        call = 1; step();
        chk("st_pc0", pc_a, 32'h28);
        stall = 1; step();
        chk("st_hold", pc_a, 32'h28);
        chk("st_top", top_a, 32'h28);
        call = 0; trap = 1; redir_v = 1; redir_pc = 32'h40; step(); idle();
        chk("trap_pc", pc_a, 32'h100);
        chk("trap_flush", 32'(empty_a), 32'd1);

        // Overflow: five calls into a four-deep stack, then five returns
        call = 1;
        step(); step(); step(); step();
        chk("ov_full4", 32'(full_a), 32'd1);
        step(); call = 0;
        chk("ov_pc", pc_a, 32'h114);
        chk("ov_full5", 32'(full_a), 32'd1);
        chk("ov_top", top_a, 32'h114);
        redir_v = 1; redir_pc = 32'h200; step(); redir_v = 0;
        ret = 1;
        step(); chk("ov_r1", pc_a, 32'h114);
        chk("ov_notfull", 32'(full_a), 32'd0);
        step(); chk("ov_r2", pc_a, 32'h110);
        step(); chk("ov_r3", pc_a, 32'h10C);
        step(); chk("ov_r4", pc_a, 32'h108);
        chk("ov_empty", 32'(empty_a), 32'd1);
        step(); chk("ov_r5_seq", pc_a, 32'h10C);

        // Call and return together: empty pushes only, non-empty replaces top
        call = 1; step();
        chk("cr2_pc", pc_a, 32'h110);
        chk("cr2_top", top_a, 32'h110);
        call = 0; ret = 0; redir_v = 1; redir_pc = 32'h300; step(); redir_v = 0;
        call = 1; ret = 1; step(); call = 0;
        chk("cr3_pc", pc_a, 32'h110);
        chk("cr3_top", top_a, 32'h304);
        chk("cr3_nempty", 32'(empty_a), 32'd0);
        step(); ret = 0;
        chk("cr3_ret", pc_a, 32'h304);
        chk("cr3_empty", 32'(empty_a), 32'd1);

        // Misaligned redirect targets
        redir_v = 1; redir_pc = 32'h41; step(); redir_v = 0;
        chk("mis_pc_a", pc_a, 32'h40);
        chk("mis_a1", 32'(mis_a), 32'd1);
        chk("mis_pc_b", pc_b, 32'h40);
        chk("mis_b1", 32'(mis_b), 32'd1);
        step();
        chk("mis_a_clr", 32'(mis_a), 32'd0);
        redir_v = 1; redir_pc = 32'h42; step(); redir_v = 0;
        chk("mis42_pc_a", pc_a, 32'h42);
        chk("mis42_a", 32'(mis_a), 32'd0);
        chk("mis42_pc_b", pc_b, 32'h40);
        chk("mis42_b", 32'(mis_b), 32'd1);
        step();
        chk("mis42_b_clr", 32'(mis_b), 32'd0);
        trap = 1; redir_v = 1; redir_pc = 32'h43; step(); idle();
        chk("mis_trap_pc", pc_a, 32'h100);
        chk("mis_trap", 32'(mis_a), 32'd0);

        // Address wrap
        redir_v = 1; redir_pc = 32'hFFFF_FFFE; step(); redir_v = 0;
        step();
        chk("wrap", pc_a, 32'h2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
